// File: rtl/envelope_follower_pkg.sv
// envelope_follower_pkg
//   Shared constants and types for the envelope follower and for mixer-side benches.
//   N_FILTERS : number of analysis bands per frame
//   ENV_W     : sample / envelope word width
//   SHIFT_W   : width of the attack/release smoothing shift controls
//   env_state_t : follower sequencing states
package envelope_follower_pkg;

  localparam int N_FILTERS = 4;
  localparam int ENV_W     = 32;
  localparam int SHIFT_W   = 5;

  // Largest positive envelope and most negative sample value
  localparam logic signed [ENV_W-1:0] ENV_MAX = {1'b0, {(ENV_W-1){1'b1}}};
  localparam logic signed [ENV_W-1:0] ENV_MIN = {1'b1, {(ENV_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECTIFY = 2'd1,
    UPDATE  = 2'd2,
    PUBLISH = 2'd3
  } env_state_t;

endpackage

// File: rtl/envelope_follower_if.sv
// envelope_follower_if
//   Frame bus between the modulator filter bank / control side and the envelope follower.
//   valid_in          : frame strobe (producer -> follower)
//   attack_shift      : smoothing shift used while the rectified input is above the envelope
//   release_shift     : smoothing shift used otherwise
//   channels_in       : signed band samples, one per band
//   envelope_channels : published envelopes (always >= 0), one per band
//   valid_out         : one-cycle pulse when envelope_channels changes
//   busy_out          : follower is processing a frame, new strobes are dropped
//   drop_count_out    : saturating count of dropped frames
//   modport master : producer/consumer side; modport slave : the follower
interface envelope_follower_if
  import envelope_follower_pkg::*;
#(
  parameter int N      = N_FILTERS,
  parameter int DROP_W = 16
) ();

  logic                    valid_in;
  logic [SHIFT_W-1:0]      attack_shift;
  logic [SHIFT_W-1:0]      release_shift;
  logic signed [ENV_W-1:0] channels_in       [N];
  logic signed [ENV_W-1:0] envelope_channels [N];
  logic                    valid_out;
  logic                    busy_out;
  logic [DROP_W-1:0]       drop_count_out;

  modport master (
    output valid_in,
    output attack_shift,
    output release_shift,
    output channels_in,
    input  envelope_channels,
    input  valid_out,
    input  busy_out,
    input  drop_count_out
  );

  modport slave (
    input  valid_in,
    input  attack_shift,
    input  release_shift,
    input  channels_in,
    output envelope_channels,
    output valid_out,
    output busy_out,
    output drop_count_out
  );

endinterface

// File: rtl/envelope_follower_update.sv
// env_update
//   Combinational one-band envelope step:
//     a   = |x| saturated (most negative input maps to the largest positive value)
//     d   = a - env                      (one bit wider, signed)
//     s   = (d > 0) ? attack_shift : release_shift
//     out = clamp(env + (d >>> s), 0, ENV_MAX)
//   Ports:
//     x             in  signed sample for this band
//     env           in  current envelope for this band (>= 0)
//     attack_shift  in  shift used when rising
//     release_shift in  shift used when falling or flat
//     env_next      out next envelope value
module env_update
  import envelope_follower_pkg::*;
(
  input  logic signed [ENV_W-1:0] x,
  input  logic signed [ENV_W-1:0] env,
  input  logic [SHIFT_W-1:0]      attack_shift,
  input  logic [SHIFT_W-1:0]      release_shift,
  output logic signed [ENV_W-1:0] env_next
);

  logic [ENV_W-1:0]        mag;
  logic signed [ENV_W:0]   diff;
  logic signed [ENV_W:0]   step;
  logic [SHIFT_W-1:0]      shift;
  logic signed [ENV_W+1:0] sum;

  always_comb begin
    // Full-wave rectify; negating the most negative value would wrap, so pin it
    if (x == ENV_MIN) begin
      mag = ENV_MAX;
    end else if (x[ENV_W-1]) begin
      mag = $unsigned(-x);
    end else begin
      mag = $unsigned(x);
    end

    diff  = $signed({1'b0, mag}) - $signed({1'b0, env});
    shift = (diff > 0) ? attack_shift : release_shift;

    // Arithmetic shift floors toward -inf, so a falling step is never smaller
    // than one LSB and the envelope cannot undershoot the rectified input.
    step = diff >>> shift;

    sum = (ENV_W+2)'(step) + (ENV_W+2)'($signed({1'b0, env}));

    if (sum < 0) begin
      env_next = '0;
    end else if (sum > (ENV_W+2)'(ENV_MAX)) begin
      env_next = ENV_MAX;
    end else begin
      env_next = sum[ENV_W-1:0];
    end
  end

endmodule

// File: rtl/envelope_follower.sv
// envelope_follower
//   Per-band envelope extraction for the vocoder analysis path. Each accepted frame is
//   processed one band at a time (rectify cycle, then update cycle) and the complete set of
//   envelopes is published atomically with a one-cycle valid_out pulse.
//   Ports:
//     clk_in    in  system clock
//     rst_n_in  in  asynchronous active-low reset
//     bus       slave side of envelope_follower_if (frame inputs, envelopes, status)
//   Parameters:
//     N_FILTERS number of bands (>= 2), must match bus.N
//     DROP_W    width of the saturating dropped-frame counter, must match bus.DROP_W
module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int N_FILTERS = envelope_follower_pkg::N_FILTERS,
  parameter int DROP_W    = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  envelope_follower_if.slave  bus
);

  localparam int IDX_W = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FILTERS - 1);

  env_state_t              state_reg;
  logic [IDX_W-1:0]        index_reg;
  logic [SHIFT_W-1:0]      attack_reg;
  logic [SHIFT_W-1:0]      release_reg;
  logic signed [ENV_W-1:0] chan_reg [N_FILTERS];
  logic signed [ENV_W-1:0] env_reg  [N_FILTERS];
  logic signed [ENV_W-1:0] out_reg  [N_FILTERS];
  logic signed [ENV_W-1:0] env_next;
  logic signed [ENV_W-1:0] env_next_reg;
  logic signed [ENV_W-1:0] x_sel;
  logic signed [ENV_W-1:0] env_sel;
  logic                    valid_reg;
  logic                    busy_reg;
  logic [DROP_W-1:0]       drop_reg;

  // Band selected by the running index
  always_comb begin
    x_sel   = chan_reg[index_reg];
    env_sel = env_reg[index_reg];
  end

  env_update u_env_update (
    .x             (x_sel),
    .env           (env_sel),
    .attack_shift  (attack_reg),
    .release_shift (release_reg),
    .env_next      (env_next)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg    <= IDLE;
      index_reg    <= '0;
      attack_reg   <= '0;
      release_reg  <= '0;
      env_next_reg <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      drop_reg     <= '0;
      for (int i = 0; i < N_FILTERS; i++) begin
        chan_reg[i] <= '0;
        env_reg[i]  <= '0;
        out_reg[i]  <= '0;
      end
    end else begin
      valid_reg <= 1'b0;

      // Any strobe while a frame is in flight (including the publish cycle) is lost
      if (bus.valid_in && busy_reg && (drop_reg != {DROP_W{1'b1}})) begin
        drop_reg <= drop_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (bus.valid_in) begin
            for (int i = 0; i < N_FILTERS; i++) begin
              chan_reg[i] <= bus.channels_in[i];
            end
            attack_reg  <= bus.attack_shift;
            release_reg <= bus.release_shift;
            index_reg   <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= RECTIFY;
          end
        end

        RECTIFY: begin
          // Register the datapath result to split the long rectify/shift/clamp path
          env_next_reg <= env_next;
          state_reg    <= UPDATE;
        end

        UPDATE: begin
          env_reg[index_reg] <= env_next_reg;
          if (index_reg == LAST_IDX) begin
            // Publish the whole frame at once; the last band comes straight from the
            // pipeline register since env_reg is being written on this same edge.
            for (int i = 0; i < N_FILTERS; i++) begin
              out_reg[i] <= (IDX_W'(i) == index_reg) ? env_next_reg : env_reg[i];
            end
            valid_reg <= 1'b1;
            state_reg <= PUBLISH;
          end else begin
            index_reg <= index_reg + 1'b1;
            state_reg <= RECTIFY;
          end
        end

        PUBLISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_FILTERS; gi++) begin : g_out
      assign bus.envelope_channels[gi] = out_reg[gi];
    end
  endgenerate

  assign bus.valid_out      = valid_reg;
  assign bus.busy_out       = busy_reg;
  assign bus.drop_count_out = drop_reg;

endmodule

// File: tb/tb_envelope_follower.sv
// tb_envelope_follower
//   Self-checking bench: a frame-level reference model (per-band arithmetic, publish
//   countdown, drop counter) is compared against the DUT outputs every cycle, and
//   directed frames pin the model with hand-computed literal envelopes.
module tb_envelope_follower;
  import envelope_follower_pkg::*;

  localparam int     NF   = N_FILTERS;
  localparam int     DW   = 8;
  localparam longint DMAX = (longint'(1) <<< DW) - 1;
  localparam longint MAXV = (longint'(1) <<< 31) - 1;
  localparam longint MINV = -(longint'(1) <<< 31);
  localparam int     LAT  = 2 * NF + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  envelope_follower_if #(.N(NF), .DROP_W(DW)) bus ();

  envelope_follower #(.N_FILTERS(NF), .DROP_W(DW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint env_m   [NF];
  longint pend_m  [NF];
  longint exp_out [NF];
  bit     exp_valid = 1'b0;
  bit     exp_busy  = 1'b0;
  int     left_m    = 0;
  longint exp_drop  = 0;
  bit     started   = 1'b0;

  function automatic longint band_step(longint x, longint e, int atk, int rel);
    longint a, d, st, n;
    a = (x < 0) ? -x : x;
    if (a > MAXV) a = MAXV;
    d  = a - e;
    st = d >>> ((d > 0) ? atk : rel);
    n  = e + st;
    if (n < 0) n = 0;
    if (n > MAXV) n = MAXV;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        env_m[i] = 0; pend_m[i] = 0; exp_out[i] = 0;
      end
      exp_valid = 1'b0; exp_busy = 1'b0; left_m = 0; exp_drop = 0;
    end else if (exp_busy) begin
      if (bus.valid_in === 1'b1) exp_drop = (exp_drop < DMAX) ? exp_drop + 1 : DMAX;
      left_m--;
      exp_valid = (left_m == 1);
      if (left_m == 1) begin
        for (int i = 0; i < NF; i++) begin
          env_m[i] = pend_m[i]; exp_out[i] = pend_m[i];
        end
      end
      if (left_m == 0) exp_busy = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (bus.valid_in === 1'b1) begin
        for (int i = 0; i < NF; i++)
          pend_m[i] = band_step(longint'(bus.channels_in[i]), env_m[i],
                                int'(bus.attack_shift), int'(bus.release_shift));
        exp_busy = 1'b1;
        left_m   = LAT;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("valid_out", longint'(bus.valid_out), longint'(exp_valid));
      chk("busy_out", longint'(bus.busy_out), longint'(exp_busy));
      chk("drop_count", longint'(bus.drop_count_out), exp_drop);
      for (int i = 0; i < NF; i++)
        chk("envelope", longint'(bus.envelope_channels[i]), exp_out[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    bus.valid_in = 1'b0;
    bus.attack_shift = '0;
    bus.release_shift = '0;
    for (int i = 0; i < NF; i++) bus.channels_in[i] = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One frame on channel 0 (others 0); returns the cycle valid_out appeared and env[0]
  task automatic send(input longint x0, input int atk, input int rel,
                      output int lat, output longint env0);
    @(posedge clk); #1;
    clear_inputs();
    bus.channels_in[0] = 32'(x0);
    bus.attack_shift   = 5'(atk);
    bus.release_shift  = 5'(rel);
    bus.valid_in       = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 1;
    while (bus.valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    env0 = longint'(bus.envelope_channels[0]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy_out !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, longint'(n < 100), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int     lat;
    int     pulses;
    longint e0;

    clear_inputs();
    #1 rst_n = 1'b0;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", longint'(bus.valid_out), 0);
    chk("reset_drop", longint'(bus.drop_count_out), 0);
    for (int i = 0; i < NF; i++) chk("reset_env", longint'(bus.envelope_channels[i]), 0);
    rst_n = 1'b1;

    // Instant attack and latency
    send(1000, 0, 0, lat, e0);
    chk("attack_latency", lat, LAT);
    chk("attack_env", e0, 1000);

    // Smoothing from zero
    do_reset();
    send(1024, 1, 0, lat, e0);  chk("smooth_1", e0, 512);
    send(1024, 1, 0, lat, e0);  chk("smooth_2", e0, 768);
    send(0, 0, 2, lat, e0);     chk("release", e0, 576);

    // Rectification and saturation
    do_reset();
    send(-2048, 0, 0, lat, e0); chk("rect_neg", e0, 2048);
    send(MINV, 0, 0, lat, e0);  chk("rect_min", e0, MAXV);
    send(MAXV, 0, 0, lat, e0);  chk("rect_max", e0, MAXV);
    send(MINV, 0, 0, lat, e0);  chk("rect_hold", e0, MAXV);

    // Busy drop: strobes on cycles 0 and 3
    do_reset();
    @(posedge clk); #1;
    clear_inputs();
    bus.channels_in[0] = 32'd500;
    bus.valid_in = 1'b1;                 // cycle 0
    @(posedge clk); #1 bus.valid_in = 1'b0;
    pulses = 0;
    for (int c = 1; c <= LAT + 3; c++) begin
      if (c == 3) bus.valid_in = 1'b1;
      if (bus.valid_out === 1'b1) pulses++;
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_one", longint'(bus.drop_count_out), 1);
    chk("drop_env", longint'(bus.envelope_channels[0]), 500);

    // Randomized traffic: random strobes, shifts and full-range samples
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      bus.valid_in      = ($urandom_range(0, 2) == 0);
      bus.attack_shift  = 5'($urandom_range(0, 31));
      bus.release_shift = 5'($urandom_range(0, 31));
      for (int i = 0; i < NF; i++)
        bus.channels_in[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                         : 32'($signed(17'($urandom)));
    end
    bus.valid_in = 1'b0;
    wait_idle("rand_idle");

    // Drop counter saturation: strobe every cycle
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.valid_in      = 1'b1;
      bus.attack_shift  = 5'($urandom_range(0, 4));
      bus.release_shift = 5'($urandom_range(0, 4));
      for (int i = 0; i < NF; i++) bus.channels_in[i] = 32'($urandom);
    end
    bus.valid_in = 1'b0;
    wait_idle("sat_idle");
    chk("drop_saturated", longint'(bus.drop_count_out), DMAX);

    // Asynchronous reset during the third band's update
    @(posedge clk); #1;
    bus.channels_in[0] = 32'd777;
    bus.attack_shift = '0;
    bus.valid_in = 1'b1;
    @(posedge clk); #1 bus.valid_in = 1'b0;      // cycle 1
    repeat (5) @(posedge clk);                     // start of cycle 6
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(bus.valid_out), 0);
    chk("midrst_busy", longint'(bus.busy_out), 0);
    chk("midrst_drop", longint'(bus.drop_count_out), 0);
    for (int i = 0; i < NF; i++) chk("midrst_env", longint'(bus.envelope_channels[i]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(1000, 0, 0, lat, e0);
    chk("post_rst_latency", lat, LAT);
    chk("post_rst_env", e0, 1000);
    for (int i = 1; i < NF; i++) chk("post_rst_lane", longint'(bus.envelope_channels[i]), 0);

    @(posedge clk); #1;
    @(negedge clk); #1;
    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
